// File: rtl/bitty_sequencer.sv
// bitty_sequencer: fetch/dispatch/execute/commit controller owning the PC of the bitty core.
//   Ports: clk, reset_n (async, active low), run (level enable);
//   instruction fetch mem_req/mem_addr/mem_ack/mem_rdata;
//   core interface instr/core_start/core_done/alu_result;
//   status pc/retired/busy.
//   Optional: define BITTY_SEQ_SINGLE_STEP_EN to add a step input and a HOLD state after every commit.
module bitty_sequencer #(
  parameter int PC_W = 16,
  parameter int IW   = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            run,
`ifdef BITTY_SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [IW-1:0]   mem_rdata,
  output logic [IW-1:0]   instr,
  output logic            core_start,
  input  logic            core_done,
  input  logic [IW-1:0]   alu_result,
  output logic [PC_W-1:0] pc,
  output logic            retired,
  output logic            busy
);
`ifdef BITTY_SEQ_SINGLE_STEP_EN
  typedef enum logic [2:0] {IDLE, FETCH, DISPATCH, EXEC, COMMIT, HOLD} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, DISPATCH, EXEC, COMMIT} state_t;
`endif
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, next_pc;
  logic [IW-1:0]   instr_q, instr_d, res_q, res_d;
  logic            is_branch, taken;
  assign is_branch = instr_q[1:0] == 2'b10;
  assign taken = is_branch && ((instr_q[3:2] == 2'b00 && res_q == IW'(0)) ||
                               (instr_q[3:2] == 2'b01 && res_q == IW'(1)) ||
                               (instr_q[3:2] == 2'b10 && res_q == IW'(2)));
  // Branch target is the 12-bit field zero-extended to the PC width.
  assign next_pc = taken ? PC_W'(instr_q[15:4]) : pc_q + PC_W'(1);
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    res_d   = res_q;
    case (state_q)
      IDLE:     state_d = run ? FETCH : IDLE;
      FETCH: begin
        instr_d = mem_ack ? mem_rdata : instr_q;
        state_d = mem_ack ? DISPATCH : FETCH;
      end
      DISPATCH: state_d = is_branch ? COMMIT : EXEC;
      EXEC: begin
        res_d   = core_done ? alu_result : res_q;
        state_d = core_done ? COMMIT : EXEC;
      end
      COMMIT: begin
        pc_d = next_pc;
`ifdef BITTY_SEQ_SINGLE_STEP_EN
        state_d = run ? HOLD : IDLE;
`else
        state_d = run ? FETCH : IDLE;
`endif
      end
`ifdef BITTY_SEQ_SINGLE_STEP_EN
      HOLD:     state_d = !run ? IDLE : step ? FETCH : HOLD;
`endif
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      res_q   <= res_d;
    end
  end
  // Outputs decode straight from the state register so reset clears them without a clock edge.
  assign mem_req    = state_q == FETCH;
  assign mem_addr   = pc_q;
  assign instr      = instr_q;
  assign core_start = state_q == DISPATCH && !is_branch;
  assign pc         = pc_q;
  assign retired    = state_q == COMMIT;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_bitty_sequencer.sv
// tb_bitty_sequencer: table-driven directed test of bitty_sequencer.
module tb_bitty_sequencer;
  logic        clk = 0, reset_n = 0, run = 0;
  logic        mem_req, mem_ack = 0, core_start, core_done = 0, retired, busy;
  logic [15:0] mem_addr, mem_rdata = 0, instr, alu_result = 0, pc;
  int          total = 0, bad = 0;

  typedef struct {
    logic [15:0] word;
    logic [15:0] alu;
    int          wt;
    int          lat;
    logic        drop;
    logic [15:0] pc0;
    logic [15:0] pc1;
  } vec_t;

  vec_t vt[13];

  bitty_sequencer dut (
    .clk(clk), .reset_n(reset_n), .run(run),
`ifdef BITTY_SEQ_SINGLE_STEP_EN
    .step(1'b1),
`endif
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .core_start(core_start), .core_done(core_done), .alu_result(alu_result),
    .pc(pc), .retired(retired), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic br;
    logic stable;
    br = v.word[1:0] == 2'b10;
    chk("fetch_req", mem_req, 1);
    chk("fetch_addr", mem_addr, v.pc0);
    stable = 1;
    for (int w = 0; w < v.wt; w++) begin
      core_done = 1;
      alu_result = 16'h0001;
      tick;
      if (!(mem_req === 1'b1 && mem_addr === v.pc0)) stable = 0;
    end
    core_done = 0;
    alu_result = 0;
    if (v.wt > 0) chk("wait_stable", stable, 1);
    mem_ack = 1;
    mem_rdata = v.word;
    tick;
    mem_ack = 0;
    mem_rdata = 16'hDEAD;
    chk("disp_req_drop", mem_req, 0);
    chk("disp_start", core_start, !br);
    chk("disp_instr", instr, v.word);
    if (!br) begin
      tick;
      chk("exec_no_start", core_start, 0);
      if (v.drop) run = 0;
      for (int i = 1; i < v.lat; i++) begin
        mem_ack = i == 1;
        mem_rdata = 16'hBEEF;
        tick;
      end
      mem_ack = 0;
      core_done = 1;
      alu_result = v.alu;
      tick;
      core_done = 0;
      alu_result = 0;
    end else tick;
    chk("commit_retired", retired, 1);
    chk("commit_pc_old", pc, v.pc0);
    chk("commit_instr", instr, v.word);
    tick;
    chk("after_pc", pc, v.pc1);
    chk("after_retired", retired, 0);
    chk("after_req", mem_req, !v.drop);
    chk("after_busy", busy, !v.drop);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{16'h0001, 16'h0005, 0, 3, 1'b0, 16'h0000, 16'h0001};
    vt[1]  = '{16'h0000, 16'h0000, 0, 1, 1'b0, 16'h0001, 16'h0002};
    vt[2]  = '{16'h0052, 16'h0000, 0, 0, 1'b0, 16'h0002, 16'h0005};
    vt[3]  = '{16'h0003, 16'h0007, 4, 2, 1'b0, 16'h0005, 16'h0006};
    vt[4]  = '{16'h0001, 16'h0002, 0, 2, 1'b0, 16'h0006, 16'h0007};
    vt[5]  = '{16'h00FA, 16'h0000, 0, 0, 1'b0, 16'h0007, 16'h000F};
    vt[6]  = '{16'h0001, 16'h0007, 0, 1, 1'b0, 16'h000F, 16'h0010};
    vt[7]  = '{16'h0056, 16'h0000, 2, 0, 1'b0, 16'h0010, 16'h0011};
    vt[8]  = '{16'h005E, 16'h0000, 0, 0, 1'b0, 16'h0011, 16'h0012};
    vt[9]  = '{16'h0001, 16'h0001, 0, 2, 1'b0, 16'h0012, 16'h0013};
    vt[10] = '{16'h0206, 16'h0000, 0, 0, 1'b0, 16'h0013, 16'h0020};
    vt[11] = '{16'h0306, 16'h0000, 0, 0, 1'b0, 16'h0020, 16'h0030};
    vt[12] = '{16'h0001, 16'h0009, 0, 2, 1'b1, 16'h0030, 16'h0031};
    tick;
    tick;
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", core_start, 0);
    chk("rst_retired", retired, 0);
    reset_n = 1;
    tick;
    chk("idle_no_run", busy, 0);
    run = 1;
    chk("req_before_run_sampled", mem_req, 0);
    tick;
    for (int k = 0; k < 13; k++) run_vec(vt[k]);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("idle_req", mem_req, 0);
      chk("idle_busy", busy, 0);
    end
    reset_n = 0;
    tick;
    reset_n = 1;
    run = 1;
    tick;
    for (int k = 0; k < 3; k++)
      run_vec('{16'h0001, 16'h0001, 0, 1, 1'b0, 16'(k), 16'(k + 1)});
    mem_ack = 1;
    mem_rdata = 16'h1231;
    tick;
    mem_ack = 0;
    tick;
    chk("exec_pc", pc, 16'h0003);
    chk("exec_busy", busy, 1);
    #1 reset_n = 0;
    #1;
    chk("async_pc", pc, 0);
    chk("async_instr", instr, 0);
    chk("async_req", mem_req, 0);
    chk("async_busy", busy, 0);
    chk("async_retired", retired, 0);
    for (int k = 0; k < 3; k++) begin
      core_done = 1;
      tick;
      chk("held_retired", retired, 0);
      chk("held_busy", busy, 0);
    end
    core_done = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
